// File: rtl/mips_muldiv_if.sv
// Operand/result bundle between the issuing pipeline and the HI/LO multiply-divide unit.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle; operands are reduced to magnitudes up front and
// the signs are reapplied in a single fix-up cycle.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mips_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]   ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]           OP_MTHI  = 3'd4;
  localparam logic [2:0]           OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + ONE_2W;
  endfunction

  state_t               r_state;
  state_t               w_state_nx;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
  logic                 r_is_div;
  logic                 r_neg_q;    // product or quotient must be negated
  logic                 r_neg_r;    // remainder must be negated
  logic                 r_bzero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_go;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_dvd;
  logic [WIDTH:0]       w_mul_sum;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_rem;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  // Issue decode: start is only taken in IDLE/DONE and loses to cancel.
  always_comb begin
    w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start && !bus.cancel;
    w_go     = w_accept && (bus.op[2] == 1'b0);
    w_a_neg  = bus.op[0] && bus.a[WIDTH-1];
    w_b_neg  = bus.op[0] && bus.b[WIDTH-1];
    w_b_zero = (bus.b == {WIDTH{1'b0}});
    w_a_mag  = w_a_neg ? neg_w(bus.a) : bus.a;
    w_b_mag  = w_b_neg ? neg_w(bus.b) : bus.b;
    // A zero divisor leaves the raw dividend to fall through as the remainder.
    w_dvd    = w_b_zero ? bus.a : w_a_mag;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_div_ge  = (r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_opnd});
    w_div_rem = r_acc[2*WIDTH-2:WIDTH-1] - r_opnd;
    if (r_is_div) begin
      if (w_div_ge) begin
        w_step = {w_div_rem, r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end
    end else if (r_acc[0]) begin
      w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else begin
      w_step = {1'b0, r_acc[2*WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX.
  always_comb begin
    w_prod = r_neg_q ? neg_2w(r_acc) : r_acc;
    if (r_is_div) begin
      w_fix_lo = r_neg_q ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      w_fix_hi = r_neg_r ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    end else begin
      w_fix_lo = w_prod[WIDTH-1:0];
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic; cancel abandons any in-flight work.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.cancel) begin
          w_state_nx = IDLE;
        end else if (w_go) begin
          w_state_nx = CALC;
        end else begin
          w_state_nx = IDLE;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          w_state_nx = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = FIX;
        end else begin
          w_state_nx = CALC;
        end
      end
      FIX: begin
        if (bus.cancel) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx = DONE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == CALC) || (w_state_nx == FIX);
      r_done <= (w_state_nx == DONE);
      r_dbz  <= (w_state_nx == DONE) && r_bzero;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_opnd   <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
    end else if (w_go) begin
      r_cnt    <= {CW{1'b0}};
      r_is_div <= bus.op[1];
      r_bzero  <= bus.op[1] && w_b_zero;
      if (bus.op[1]) begin
        r_acc   <= {{WIDTH{1'b0}}, w_dvd};
        r_opnd  <= w_b_mag;
        r_neg_q <= !w_b_zero && (w_a_neg ^ w_b_neg);
        r_neg_r <= !w_b_zero && w_a_neg;
      end else begin
        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
        r_opnd  <= w_a_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= 1'b0;
      end
    end else if (r_state == CALC) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Architectural HI/LO: direct moves at accept, results at the end of FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else if (w_accept && (bus.op == OP_MTHI)) begin
      r_hi <= bus.a;
    end else if (w_accept && (bus.op == OP_MTLO)) begin
      r_lo <= bus.a;
    end else if ((r_state == FIX) && !bus.cancel) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv (WIDTH=32).
module tb_mips_muldiv;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  vec_t vecs[11];

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output int bcyc, output bit moved);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = bus.hi;
    l0 = bus.lo;
    dcyc = 0;
    bcyc = 0;
    moved = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.done) begin
        dcyc = c;
        break;
      end
      if (bus.busy) bcyc++;
      if (bus.busy && ((bus.hi !== h0) || (bus.lo !== l0))) moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic watch_no_done(input int n, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (bus.done) seen = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    int dcyc;
    int bcyc;
    bit moved;
    bit seen;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{3'd2, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{3'd2, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[6]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[7]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{3'd3, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[10] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset dbz",  32'(bus.div_by_zero), 32'd0);
    check("reset hi",   bus.hi, 32'd0);
    check("reset lo",   bus.lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven mul/div vectors.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(dcyc, bcyc, moved);
      check($sformatf("v%0d done_cycle", i), 32'(dcyc), 32'd34);
      check($sformatf("v%0d busy_cycles", i), 32'(bcyc), 32'd33);
      check($sformatf("v%0d hilo_stable", i), 32'(moved), 32'd0);
      check($sformatf("v%0d hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), bus.lo, vecs[i].lo);
      check($sformatf("v%0d dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
      @(negedge clk);
      check($sformatf("v%0d done_pulse", i), 32'(bus.done), 32'd0);
    end

    // Back-to-back issue in the DONE cycle.
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(dcyc, bcyc, moved);
    check("b2b first done", 32'(dcyc), 32'd34);
    issue(3'd0, 32'd3, 32'd5);
    wait_done(dcyc, bcyc, moved);
    check("b2b second done_cycle", 32'(dcyc), 32'd34);
    check("b2b second hi", bus.hi, 32'd0);
    check("b2b second lo", bus.lo, 32'd15);
    @(negedge clk);

    // MTHI / MTLO write at accept, never busy or done.
    issue(3'd4, 32'h0000_CAFE, 32'd0);
    check("mthi hi", bus.hi, 32'h0000_CAFE);
    check("mthi busy", 32'(bus.busy), 32'd0);
    check("mthi done", 32'(bus.done), 32'd0);
    issue(3'd5, 32'h0000_1234, 32'd0);
    check("mtlo lo", bus.lo, 32'h0000_1234);
    check("mtlo hi", bus.hi, 32'h0000_CAFE);
    check("mtlo busy", 32'(bus.busy), 32'd0);

    // Reserved op is a no-op.
    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("rsvd busy", 32'(bus.busy), 32'd0);
    check("rsvd hi", bus.hi, 32'h0000_CAFE);
    check("rsvd lo", bus.lo, 32'h0000_1234);
    watch_no_done(5, seen);
    check("rsvd no_done", 32'(seen), 32'd0);

    // MULT, ignored start while busy, cancel in cycle 10.
    issue(3'd1, 32'd5, 32'd6);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a     = 32'h0000_DEAD;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start busy", 32'(bus.busy), 32'd1);
    check("busy_start lo", bus.lo, 32'h0000_1234);
    repeat (6) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel busy", 32'(bus.busy), 32'd0);
    check("cancel lo", bus.lo, 32'h0000_1234);
    check("cancel hi", bus.hi, 32'h0000_CAFE);
    watch_no_done(40, seen);
    check("cancel no_done", 32'(seen), 32'd0);

    // Cancel in FIX (cycle 33) keeps the old HI/LO.
    issue(3'd0, 32'd2, 32'd3);
    repeat (32) @(negedge clk);
    check("fix busy", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("fix_cancel busy", 32'(bus.busy), 32'd0);
    check("fix_cancel hi", bus.hi, 32'h0000_CAFE);
    check("fix_cancel lo", bus.lo, 32'h0000_1234);
    watch_no_done(5, seen);
    check("fix_cancel no_done", 32'(seen), 32'd0);

    // Cancel beats a simultaneous start in DONE.
    issue(3'd0, 32'd2, 32'd3);
    wait_done(dcyc, bcyc, moved);
    check("cvs done_cycle", 32'(dcyc), 32'd34);
    check("cvs lo", bus.lo, 32'd6);
    bus.start  = 1'b1;
    bus.op     = 3'd0;
    bus.a      = 32'd9;
    bus.b      = 32'd9;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cvs busy", 32'(bus.busy), 32'd0);
    watch_no_done(40, seen);
    check("cvs no_done", 32'(seen), 32'd0);
    check("cvs lo kept", bus.lo, 32'd6);

    // Reset in the middle of a DIVU.
    issue(3'd2, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid busy", 32'(bus.busy), 32'd0);
    check("rst_mid done", 32'(bus.done), 32'd0);
    check("rst_mid hi", bus.hi, 32'd0);
    check("rst_mid lo", bus.lo, 32'd0);
    reset = 1'b0;
    watch_no_done(40, seen);
    check("rst_mid no_done", 32'(seen), 32'd0);
    check("rst_mid lo after", bus.lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width; legal values are even and >= 4.
REQ-002 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset: synchronous, active-high; clock clk.
REQ-004 The block SHALL have port start, input, 1, request to issue op with operands a/b.
REQ-005 The block SHALL have port op, input, 3, operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 reserved (no effect).
REQ-006 The block SHALL have ports a and b, input, WIDTH each, rs/rt operands; b is the divisor.
REQ-007 The block SHALL have port cancel, input, 1, pipeline squash that abandons the operation in flight.
REQ-008 The block SHALL have port busy, output, 1, high while a mul/div is in flight.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse with hi/lo valid.
REQ-010 The block SHALL have port div_by_zero, output, 1, qualified by done; high when a DIV/DIVU had b==0.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers (MFHI/MFLO read them directly).

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIX, DONE; busy=1 exactly in CALC and FIX, done=1 exactly in DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in CALC/FIX SHALL be ignored and not queued.
REQ-014 An accepted mul/div SHALL latch operand magnitudes (signed ops: two's-complement absolute value) plus result signs, then enter CALC.
REQ-015 CALC SHALL last exactly WIDTH cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, using a 2*WIDTH internal accumulator.
REQ-016 FIX SHALL last 1 cycle, apply sign correction, and write hi/lo at its closing edge; hi/lo SHALL NOT change during CALC.
REQ-017 Latency: start accepted at edge of cycle 0 -> done high in cycle WIDTH+2; back-to-back start in DONE SHALL be accepted.
REQ-018 Multiply: {hi,lo} = full 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
REQ-019 Divide: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign (DIV) or unsigned (DIVU).
REQ-020 DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0, div_by_zero=0.
REQ-021 Divide with b==0 SHALL give lo = all ones, hi = a (unmodified), div_by_zero=1 in DONE, same latency.
REQ-022 MTHI/MTLO SHALL write a to hi/lo at the accept edge, stay in or return to IDLE, and assert neither busy nor done.
REQ-023 cancel in CALC or FIX SHALL return to IDLE at the next edge, leave hi/lo at pre-operation values, and produce no done.
REQ-024 cancel SHALL take priority over a simultaneous start in IDLE/DONE; that start SHALL be discarded.
REQ-025 Reserved op with start SHALL be a no-op (DONE still falls to IDLE).

Reset
REQ-026 reset SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0 at the next edge, including mid-operation, and take priority over start and cancel.

Verification (WIDTH=32)
REQ-027 MULT a=0xFFFFFFFD, b=7 -> done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high cycles 1-33.
REQ-028 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; second MULTU issued in DONE cycle completes 34 cycles later.
REQ-029 DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1 with done.
REQ-031 MTLO 0x1234, then MULT, cancel in cycle 10 -> busy low next cycle, lo=0x1234 retained, no done; start during busy ignored.
REQ-032 reset asserted mid-DIVU -> next cycle busy=0, done=0, hi=lo=0, FIX never reached.
